// File: rtl/dmem_arb_pkg.sv
// Shared types and defaults for the CPU/debug data-memory arbiter.
// The grant helper holds the round-robin rule so the top level only adds reset gating.
package dmem_arb_pkg;

   localparam int DEF_AW    = 32;
   localparam int DEF_DW    = 32;
   localparam int DEF_CNT_W = 16;

   typedef enum logic [1:0] {
      GNT_NONE = 2'd0,
      GNT_CPU  = 2'd1,
      GNT_DBG  = 2'd2
   } grant_e;

   // On contention, whoever was served last yields to the other requester.
   function automatic grant_e pickGrant(input logic cpuReq, input logic dbgElig,
                                        input grant_e lastGnt);
      grant_e g;
      if (cpuReq && dbgElig) begin
         g = (lastGnt == GNT_CPU) ? GNT_DBG : GNT_CPU;
      end else if (cpuReq) begin
         g = GNT_CPU;
      end else if (dbgElig) begin
         g = GNT_DBG;
      end else begin
         g = GNT_NONE;
      end
      return g;
   endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter: it stops at its all-ones value instead of wrapping.
// It is cleared by a synchronous active-low reset.
module sat_counter #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         inc,
   output logic [W-1:0] count
);

   localparam logic [W-1:0] CNT_MAX = {W{1'b1}};
   localparam logic [W-1:0] CNT_ONE = {{(W-1){1'b0}}, 1'b1};

   // Count register with clear and saturation
   always_ff @(posedge clk) begin
      if (!reset) begin
         count <= {W{1'b0}};
      end else if (inc && (count != CNT_MAX)) begin
         count <= count + CNT_ONE;
      end else begin
         count <= count;
      end
   end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares one data-memory port between the CPU Memory stage and a debug/loader port.
// The grant is combinational. A debug access completes with a one-cycle ack that carries the registered read data.
module dmem_arbiter
   import dmem_arb_pkg::*;
#(
   parameter int AW    = DEF_AW,
   parameter int DW    = DEF_DW,
   parameter int CNT_W = DEF_CNT_W
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             cpu_req,
   input  logic             cpu_we,
   input  logic [AW-1:0]    cpu_adr,
   input  logic [DW-1:0]    cpu_wd,
   output logic [DW-1:0]    cpu_rd,
   output logic             cpu_stall,
   input  logic             dbg_req,
   input  logic             dbg_we,
   input  logic [AW-1:0]    dbg_adr,
   input  logic [DW-1:0]    dbg_wd,
   output logic [DW-1:0]    dbg_rd,
   output logic             dbg_ack,
   output logic             mem_we,
   output logic [AW-1:0]    mem_a,
   output logic [DW-1:0]    mem_wd,
   input  logic [DW-1:0]    mem_rd,
   output logic [CNT_W-1:0] stall_cnt
);

   grant_e          gnt;
   grant_e          lastQ;
   logic            ackQ;
   logic            dbgElig;
   logic [DW-1:0]   dbgRdQ;

   // Grant decision. Reset forces NONE, so no write or stall escapes while reset is asserted.
   always_comb begin
      gnt     = GNT_NONE;
      dbgElig = dbg_req & ~ackQ;
      if (!reset) begin
         gnt = GNT_NONE;
      end else begin
         gnt = pickGrant(cpu_req, dbgElig, lastQ);
      end
   end

   // Steer the granted requester onto the memory port
   always_comb begin
      mem_we = 1'b0;
      mem_a  = {AW{1'b0}};
      mem_wd = {DW{1'b0}};
      case (gnt)
         GNT_CPU: begin
            mem_we = cpu_we;
            mem_a  = cpu_adr;
            mem_wd = cpu_wd;
         end
         GNT_DBG: begin
            mem_we = dbg_we;
            mem_a  = dbg_adr;
            mem_wd = dbg_wd;
         end
         default: begin
            mem_we = 1'b0;
            mem_a  = {AW{1'b0}};
            mem_wd = {DW{1'b0}};
         end
      endcase
   end

   assign cpu_stall = reset & cpu_req & (gnt != GNT_CPU);
   assign cpu_rd    = mem_rd;
   assign dbg_ack   = ackQ;
   assign dbg_rd    = dbgRdQ;

   // Round-robin history, ack pulse and captured debug read data
   always_ff @(posedge clk) begin
      if (!reset) begin
         lastQ  <= GNT_CPU;
         ackQ   <= 1'b0;
         dbgRdQ <= {DW{1'b0}};
      end else begin
         ackQ <= (gnt == GNT_DBG);
         if (gnt == GNT_DBG) begin
            dbgRdQ <= mem_rd;
         end else begin
            dbgRdQ <= dbgRdQ;
         end
         if (gnt != GNT_NONE) begin
            lastQ <= gnt;
         end else begin
            lastQ <= lastQ;
         end
      end
   end

   sat_counter #(
      .W(CNT_W)
   ) u_stallCnt (
      .clk   (clk),
      .reset (reset),
      .inc   (cpu_stall),
      .count (stall_cnt)
   );

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed scenarios and then randomized traffic.
// Everything is checked against a cycle-level reference model of the arbitration rules.
module tb_dmem_arbiter;

   logic        clk = 1'b0;
   logic        reset;
   logic        cpu_req, cpu_we, dbg_req, dbg_we;
   logic [31:0] cpu_adr, cpu_wd, dbg_adr, dbg_wd;
   logic [31:0] cpu_rd, dbg_rd, mem_a, mem_wd, mem_rd;
   logic        cpu_stall, dbg_ack, mem_we;
   logic [15:0] stall_cnt;
   logic [31:0] cpu_rd4, dbg_rd4, mem_a4, mem_wd4;
   logic        cpu_stall4, dbg_ack4, mem_we4;
   logic [3:0]  stall_cnt4;

   logic [31:0] memArr [256];
   logic [31:0] refMem [256];

   int total = 0;
   int bad   = 0;

   // model state: ack pending, last served was debug, captured read data, stall counts
   bit          mAck, mLastDbg;
   logic [31:0] mRd;
   int          mCnt, mCnt4;
   logic        obsWe, obsStall, obsAck;
   logic [31:0] obsA, obsRd;

   always #5 clk = ~clk;

   assign mem_rd = memArr[mem_a[9:2]];

   always @(posedge clk) begin
      if (mem_we) memArr[mem_a[9:2]] <= mem_wd;
   end

   dmem_arbiter dut (
      .clk(clk), .reset(reset),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_adr(cpu_adr), .cpu_wd(cpu_wd),
      .cpu_rd(cpu_rd), .cpu_stall(cpu_stall),
      .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_adr(dbg_adr), .dbg_wd(dbg_wd),
      .dbg_rd(dbg_rd), .dbg_ack(dbg_ack),
      .mem_we(mem_we), .mem_a(mem_a), .mem_wd(mem_wd), .mem_rd(mem_rd),
      .stall_cnt(stall_cnt)
   );

   dmem_arbiter #(.CNT_W(4)) dut4 (
      .clk(clk), .reset(reset),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_adr(cpu_adr), .cpu_wd(cpu_wd),
      .cpu_rd(cpu_rd4), .cpu_stall(cpu_stall4),
      .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_adr(dbg_adr), .dbg_wd(dbg_wd),
      .dbg_rd(dbg_rd4), .dbg_ack(dbg_ack4),
      .mem_we(mem_we4), .mem_a(mem_a4), .mem_wd(mem_wd4), .mem_rd(mem_rd),
      .stall_cnt(stall_cnt4)
   );

   task automatic checkVal(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=0x%0h expected=0x%0h at t=%0t", tag, got, exp, $time);
      end
   endtask

   // One clock: check outputs mid-cycle against the model, then advance the model past the edge
   task automatic step();
      int          g;   // 0 = none, 1 = cpu, 2 = dbg
      bit          elig, expStall;
      logic        expWe;
      logic [31:0] expA, expWd;
      @(negedge clk);
      elig = dbg_req && !mAck;
      if (!reset)                g = 0;
      else if (cpu_req && elig)  g = mLastDbg ? 1 : 2;
      else if (cpu_req)          g = 1;
      else if (elig)             g = 2;
      else                       g = 0;
      expWe = 1'b0; expA = 32'd0; expWd = 32'd0;
      if (g == 1) begin expWe = cpu_we; expA = cpu_adr; expWd = cpu_wd; end
      if (g == 2) begin expWe = dbg_we; expA = dbg_adr; expWd = dbg_wd; end
      expStall = reset && cpu_req && (g != 1);

      checkVal("mem_we",    {63'd0, mem_we},    {63'd0, expWe});
      checkVal("mem_a",     {32'd0, mem_a},     {32'd0, expA});
      checkVal("mem_wd",    {32'd0, mem_wd},    {32'd0, expWd});
      checkVal("cpu_stall", {63'd0, cpu_stall}, {63'd0, expStall});
      checkVal("cpu_rd",    {32'd0, cpu_rd},    {32'd0, refMem[expA[9:2]]});
      checkVal("dbg_ack",   {63'd0, dbg_ack},   {63'd0, mAck});
      checkVal("dbg_rd",    {32'd0, dbg_rd},    {32'd0, mRd});
      checkVal("stall_cnt", {48'd0, stall_cnt}, 64'(mCnt));
      checkVal("stall_cnt4",{60'd0, stall_cnt4},64'(mCnt4));
      checkVal("mem_we4",   {63'd0, mem_we4},   {63'd0, expWe});
      checkVal("mem_a4",    {32'd0, mem_a4},    {32'd0, expA});
      checkVal("mem_wd4",   {32'd0, mem_wd4},   {32'd0, expWd});
      checkVal("cpu_stall4",{63'd0, cpu_stall4},{63'd0, expStall});
      checkVal("cpu_rd4",   {32'd0, cpu_rd4},   {32'd0, refMem[expA[9:2]]});
      checkVal("dbg_ack4",  {63'd0, dbg_ack4},  {63'd0, mAck});
      checkVal("dbg_rd4",   {32'd0, dbg_rd4},   {32'd0, mRd});
      obsWe = mem_we; obsA = mem_a; obsStall = cpu_stall; obsAck = dbg_ack; obsRd = dbg_rd;

      if (!reset) begin
         mAck = 1'b0; mRd = 32'd0; mLastDbg = 1'b0; mCnt = 0; mCnt4 = 0;
      end else begin
         if (expStall) begin
            if (mCnt < 65535) mCnt++;
            if (mCnt4 < 15) mCnt4++;
         end
         mAck = (g == 2);
         if (g == 2) mRd = refMem[dbg_adr[9:2]];
         if (g != 0) mLastDbg = (g == 2);
         if (expWe) refMem[expA[9:2]] = expWd;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      cpu_req = 1'b0; cpu_we = 1'b0; cpu_adr = 32'd0; cpu_wd = 32'd0;
      dbg_req = 1'b0; dbg_we = 1'b0; dbg_adr = 32'd0; dbg_wd = 32'd0;
   endtask

   task automatic pulseReset();
      reset = 1'b0;
      step();
      reset = 1'b1;
   endtask

   initial begin
      for (int i = 0; i < 256; i++) begin
         memArr[i] = 32'd0;
         refMem[i] = 32'd0;
      end
      idle();
      reset = 1'b0;
      mAck = 1'b0; mLastDbg = 1'b0; mRd = 32'd0; mCnt = 0; mCnt4 = 0;
      @(posedge clk);
      #1;

      // requests while in reset must not reach memory or stall the CPU
      cpu_req = 1'b1; cpu_we = 1'b1; dbg_req = 1'b1; dbg_we = 1'b1;
      step();
      checkVal("rst_we", {63'd0, obsWe}, 64'd0);
      checkVal("rst_stall", {63'd0, obsStall}, 64'd0);
      idle();
      reset = 1'b1;

      // CPU store alone
      cpu_req = 1'b1; cpu_we = 1'b1; cpu_adr = 32'h40; cpu_wd = 32'hDEADBEEF;
      step();
      checkVal("cpu_only_we", {63'd0, obsWe}, 64'd1);
      checkVal("cpu_only_a", {32'd0, obsA}, 64'h40);
      checkVal("cpu_only_stall", {63'd0, obsStall}, 64'd0);
      cpu_adr = 32'h80; cpu_wd = 32'h12345678;
      step();
      idle();
      step();
      checkVal("cpu_only_cnt", {48'd0, stall_cnt}, 64'd0);

      // debug read alone: ack and data exactly one cycle after the grant
      dbg_req = 1'b1; dbg_adr = 32'h80;
      step();
      step();
      checkVal("dbg_rd_ack", {63'd0, obsAck}, 64'd1);
      checkVal("dbg_rd_val", {32'd0, obsRd}, 64'h12345678);
      dbg_req = 1'b0;
      step();
      checkVal("dbg_ack_single", {63'd0, obsAck}, 64'd0);

      // contention straight after reset: debug wins first, CPU next
      pulseReset();
      cpu_req = 1'b1; cpu_adr = 32'h40; dbg_req = 1'b1; dbg_adr = 32'h80;
      step();
      checkVal("cont_stall1", {63'd0, obsStall}, 64'd1);
      step();
      checkVal("cont_stall2", {63'd0, obsStall}, 64'd0);
      checkVal("cont_ack2", {63'd0, obsAck}, 64'd1);
      checkVal("cont_cnt", {48'd0, stall_cnt}, 64'd1);

      // six cycles of sustained contention alternate and stall three times
      idle();
      pulseReset();
      cpu_req = 1'b1; dbg_req = 1'b1; dbg_adr = 32'h40;
      for (int i = 0; i < 6; i++) step();
      checkVal("alt_cnt", {48'd0, stall_cnt}, 64'd3);

      // 20 stall cycles saturate the 4-bit counter
      pulseReset();
      cpu_req = 1'b1; dbg_req = 1'b1;
      for (int i = 0; i < 40; i++) step();
      checkVal("sat_cnt4", {60'd0, stall_cnt4}, 64'd15);
      checkVal("sat_cnt16", {48'd0, stall_cnt}, 64'd20);
      for (int i = 0; i < 4; i++) step();
      checkVal("sat_hold4", {60'd0, stall_cnt4}, 64'd15);

      // reset in the cycle a debug access would be granted
      idle();
      step();
      step();
      dbg_req = 1'b1; dbg_adr = 32'h80;
      reset = 1'b0;
      step();
      reset = 1'b1;
      dbg_req = 1'b0;
      step();
      checkVal("rstdbg_ack", {63'd0, obsAck}, 64'd0);
      checkVal("rstdbg_rd", {32'd0, obsRd}, 64'd0);
      checkVal("rstdbg_cnt", {48'd0, stall_cnt}, 64'd0);
      cpu_req = 1'b1; dbg_req = 1'b1;
      step();
      checkVal("rstdbg_last", {63'd0, obsStall}, 64'd1);
      idle();
      step();

      // randomized traffic with a protocol-respecting debug requester
      for (int i = 0; i < 400; i++) begin
         reset   = ($urandom_range(0, 39) != 0);
         cpu_req = $urandom_range(0, 1);
         cpu_we  = $urandom_range(0, 1);
         cpu_adr = {22'd0, 8'($urandom_range(0, 255)), 2'b00};
         cpu_wd  = $urandom;
         if (dbg_req && dbg_ack) begin
            dbg_req = 1'b0;
         end else if (dbg_req && ($urandom_range(0, 15) == 0)) begin
            dbg_req = 1'b0;
         end else if (!dbg_req && ($urandom_range(0, 2) == 0)) begin
            dbg_req = 1'b1;
            dbg_we  = $urandom_range(0, 1);
            dbg_adr = {22'd0, 8'($urandom_range(0, 255)), 2'b00};
            dbg_wd  = $urandom;
         end
         step();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter AW, default 32, address width of all ports.
REQ-002 Parameter DW, default 32, data width of all ports.
REQ-003 Parameter CNT_W, default 16, width of the stall performance counter.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 reset  input  1  synchronous, active-low reset (asserted when 0, sampled on clk rising edge).
REQ-006 cpu_req  input  1  CPU data-port access request, combinational from pipeline Memory stage.
REQ-007 cpu_we  input  1  CPU write enable (store).
REQ-008 cpu_adr  input  AW  CPU byte address.
REQ-009 cpu_wd  input  DW  CPU write data.
REQ-010 cpu_rd  output  DW  CPU read data; combinational passthrough of mem_rd.
REQ-011 cpu_stall  output  1  CPU must hold its Memory stage this cycle.
REQ-012 dbg_req  input  1  debug/loader request; held high until dbg_ack.
REQ-013 dbg_we, dbg_adr, dbg_wd  input  1/AW/DW  debug write enable, address, write data; stable while dbg_req high.
REQ-014 dbg_rd  output  DW  registered debug read data, valid when dbg_ack=1.
REQ-015 dbg_ack  output  1  one-cycle completion pulse for a debug access.
REQ-016 mem_we, mem_a, mem_wd  output  1/AW/DW  to data memory (combinational read, write on clk edge).
REQ-017 mem_rd  input  DW  data memory read data.
REQ-018 stall_cnt  output  CNT_W  number of cycles cpu_stall was 1, saturating.

Function
REQ-019 Grant per cycle SHALL be one of NONE, CPU, DBG, decided combinationally from cpu_req, dbg_req, ack_q, last_q.
REQ-020 dbg eligible = dbg_req & ~ack_q; DBG SHALL NOT be granted in a cycle where dbg_ack=1.
REQ-021 Only cpu_req (or cpu_req with dbg ineligible) SHALL grant CPU; only eligible dbg SHALL grant DBG; neither SHALL grant NONE.
REQ-022 Both requesting and dbg eligible: grant DBG if last_q=CPU, else CPU (round-robin); no requester waits more than 1 contended cycle.
REQ-023 last_q SHALL update to the granted requester on every CPU/DBG grant and hold on NONE.
REQ-024 Mem port SHALL carry the granted requester's we/adr/wd; on NONE mem_we=0, mem_a=0, mem_wd=0.
REQ-025 cpu_stall = cpu_req & (grant != CPU); mem_we SHALL never be 1 for an ungranted requester.
REQ-026 Debug access latency: grant in cycle N, dbg_ack=1 and dbg_rd=mem_rd (captured at end of N) in cycle N+1, exactly one cycle.
REQ-027 dbg_rd SHALL hold its value until the next DBG grant; for debug writes it captures mem_rd at the written address (don't-care to bench).
REQ-028 stall_cnt SHALL increment by 1 each cycle cpu_stall=1, saturating at 2^CNT_W-1 without wrap.
REQ-029 dbg_req deasserted before ack SHALL be treated as abandonment; no ack is generated if never granted.

Reset
REQ-030 While reset=0 at a clk edge: ack_q=0, dbg_ack=0, dbg_rd=0, last_q=CPU, stall_cnt=0.
REQ-031 Reset during a granted debug cycle SHALL suppress the ack; requester re-issues after reset; memory write in that cycle is not guaranteed.
REQ-032 Outputs during reset: mem_we=0 and cpu_stall=0 regardless of requests.

Structure
REQ-033 Package dmem_arb_pkg SHALL hold the grant enum (GNT_NONE, GNT_CPU, GNT_DBG) and default width constants.
REQ-034 One sub-module sat_counter (parameter W, inputs clk, reset, inc; output count) SHALL implement stall_cnt.
REQ-035 Arbiter state SHALL be only last_q, ack_q, dbg_rd register and the counter; no other storage.

Verification
REQ-036 CPU only: cpu_req=1, cpu_we=1, adr=0x40, wd=0xDEADBEEF -> mem_we=1, mem_a=0x40, cpu_stall=0, stall_cnt stays 0.
REQ-037 Debug read alone: memory 0x80=0x12345678, dbg_req=1, dbg_we=0, adr=0x80 -> next cycle dbg_ack=1, dbg_rd=0x12345678, single pulse.
REQ-038 Contention after reset: cpu_req=1 and dbg_req=1 in same cycle -> DBG granted, cpu_stall=1, stall_cnt=1; next cycle CPU granted, dbg_ack=1, cpu_stall=0.
REQ-039 Continuous contention 6 cycles, dbg re-requesting after each ack -> grants alternate DBG,CPU,DBG,CPU,...; stall_cnt=3.
REQ-040 Saturation with CNT_W=4: force 20 stall cycles -> stall_cnt=15, holds.
REQ-041 Reset=0 in DBG grant cycle -> no dbg_ack next cycle, dbg_rd=0, stall_cnt=0, last_q=CPU.
